// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   HEX_SEG  : 16-entry hex-to-segment table, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_OFF  : all segments dark
//   AN_OFF   : all anodes disabled
//   state_t  : scan state machine encoding {BLANK, DRIVE}
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   nibble_i  in  4  hex digit 0..F
//   seg_o     out 7  active-low segment pattern {g,f,e,d,c,b,a}
module seg7_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Seven-segment scan driver. Follows the external digit-select counter,
// double-buffers a 32-bit display value (commits only at frame boundaries so
// digits never tear), blanks all anodes for DEAD_CYCLES clocks after every
// digit change, and drives registered active-low anode/segment/dp outputs.
//
// Optional feature: define SEG_SCAN_LZ_BLANK_EN to enable leading-zero
// suppression (digits above the highest nonzero nibble show dark segments;
// digit 0 is never suppressed).
//
// Ports:
//   clk          in  1   system clock
//   rst          in  1   asynchronous active-high reset
//   digit_sel    in  3   digit index from the scan counter
//   value        in  32  display value, nibble d shown on digit d
//   dp_mask      in  8   decimal-point enables, bit d for digit d
//   load         in  1   capture value/dp_mask into staging
//   load_ack     out 1   pulse when staged data commits to the display
//   frame_start  out 1   pulse at each frame boundary
//   an           out 8   anodes, active-low
//   seg          out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp           out 1   decimal point, active-low
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DEAD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  digit_sel,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [7:0] DEAD_INIT = DEAD_CYCLES[7:0];

    // state
    logic [2:0]  sel_q;
    logic [31:0] stage_val_q, stage_val_d;
    logic [7:0]  stage_dp_q,  stage_dp_d;
    logic        pending_q,   pending_d;
    logic [31:0] disp_val_q,  disp_val_d;
    logic [7:0]  disp_dp_q,   disp_dp_d;
    logic [7:0]  dead_cnt_q,  dead_cnt_d;
    state_t      state_q,     state_d;

    // registered outputs
    logic [7:0]  an_q,          an_d;
    logic [6:0]  seg_q,         seg_d;
    logic        dp_q,          dp_d;
    logic        load_ack_q,    load_ack_d;
    logic        frame_start_q, frame_start_d;

    logic        sel_change;
    logic        frame_edge;
    logic        blank_d;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_glyph;
    logic        lz_blank;

    // Outputs are computed from next-state values so they are valid the same
    // edge the state changes; the nibble therefore comes from disp_val_d.
    assign cur_nibble = disp_val_d[{digit_sel, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_glyph)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // upper_zero[d]: nibbles d..7 of the committed value are all zero.
    logic [7:1] upper_zero;
    for (genvar gi = 1; gi < 8; gi++) begin : g_lz
        if (gi == 7) begin : g_top
            assign upper_zero[gi] = (disp_val_d[4*gi +: 4] == 4'h0);
        end else begin : g_mid
            assign upper_zero[gi] = (disp_val_d[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
        end
    end
    assign lz_blank = (digit_sel != 3'd0) && upper_zero[digit_sel];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        sel_change  = (digit_sel != sel_q);
        frame_edge  = (digit_sel == 3'd0) && (sel_q != 3'd0);

        stage_val_d = stage_val_q;
        stage_dp_d  = stage_dp_q;
        pending_d   = pending_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        load_ack_d  = 1'b0;

        // Commit path. A load landing on the boundary goes straight to the
        // display so it is not delayed a whole frame.
        if (frame_edge) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_mask;
                load_ack_d = 1'b1;
            end else if (pending_q) begin
                disp_val_d = stage_val_q;
                disp_dp_d  = stage_dp_q;
                load_ack_d = 1'b1;
            end
            pending_d = 1'b0;
        end else if (load) begin
            stage_val_d = value;
            stage_dp_d  = dp_mask;
            pending_d   = 1'b1;
        end
        frame_start_d = frame_edge;

        // Scan state machine: any digit change restarts the dead time.
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        if (sel_change) begin
            dead_cnt_d = DEAD_INIT;
            state_d    = (DEAD_INIT == 8'd0) ? DRIVE : BLANK;
        end else if (state_q == BLANK) begin
            if (dead_cnt_q == 8'd0) begin
                state_d = DRIVE;
            end else begin
                dead_cnt_d = dead_cnt_q - 8'd1;
            end
        end

        // The change cycle itself is always dark, so even with zero dead time
        // the new digit appears one cycle after the change is sampled.
        blank_d = sel_change || (state_d == BLANK);
        an_d    = blank_d ? AN_OFF : ~(8'b1 << digit_sel);
        seg_d   = (blank_d || lz_blank) ? SEG_OFF : cur_glyph;
        dp_d    = blank_d ? 1'b1 : ~disp_dp_d[digit_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q         <= 3'd0;
            stage_val_q   <= 32'd0;
            stage_dp_q    <= 8'd0;
            pending_q     <= 1'b0;
            disp_val_q    <= 32'd0;
            disp_dp_q     <= 8'd0;
            dead_cnt_q    <= DEAD_INIT;
            state_q       <= BLANK;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sel_q         <= digit_sel;
            stage_val_q   <= stage_val_d;
            stage_dp_q    <= stage_dp_d;
            pending_q     <= pending_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            dead_cnt_q    <= dead_cnt_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver (DEAD_CYCLES=4). Honors SEG_SCAN_LZ_BLANK_EN.
module tb_seg_scan_driver;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  digit_sel;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg_scan_driver #(.DEAD_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_sel   (digit_sel),
        .value       (value),
        .dp_mask     (dp_mask),
        .load        (load),
        .load_ack    (load_ack),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;

    // Expected {an, seg, dp, load_ack, frame_start}
    logic [17:0] sb_q[$];

    // Reference model: time since last digit change rather than a state machine
    logic [2:0]  m_sel;
    int          m_since;
    logic [31:0] m_disp, m_stage;
    logic [7:0]  m_dp, m_stage_dp;
    logic        m_pend;

    typedef struct {
        logic [2:0]  sel;
        logic        ld;
        logic [31:0] val;
        logic [7:0]  dpm;
        int          n;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] shown(input logic [2:0] s);
        logic [31:0] upper;
        upper = m_disp >> (4 * s);
        shown = glyph(upper[3:0]);
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (s != 3'd0 && upper == 32'd0) shown = 7'h7F;
`endif
    endfunction

    task automatic model_reset();
        m_sel = 3'd0; m_since = 0; m_disp = 32'd0; m_stage = 32'd0;
        m_dp = 8'd0; m_stage_dp = 8'd0; m_pend = 1'b0;
        sb_q.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // One clock: drive inputs, push model expectation, sample after the edge.
    task automatic step(input logic [2:0] s, input logic ld, input logic [31:0] v, input logic [7:0] m);
        logic        chg, bnd, e_ack;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [17:0] e;
        digit_sel = s; load = ld; value = v; dp_mask = m;
        chg = (s != m_sel);
        bnd = (s == 3'd0) && (m_sel != 3'd0);
        e_ack = 1'b0;
        if (bnd) begin
            if (ld) begin
                m_disp = v; m_dp = m; e_ack = 1'b1;
            end else if (m_pend) begin
                m_disp = m_stage; m_dp = m_stage_dp; e_ack = 1'b1;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_stage = v; m_stage_dp = m; m_pend = 1'b1;
        end
        m_since = chg ? 0 : ((m_since > 1000) ? m_since : m_since + 1);
        m_sel = s;
        if (m_since > D) begin
            e_an = ~(8'd1 << s); e_seg = shown(s); e_dp = ~m_dp[s];
        end else begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end
        sb_q.push_back({e_an, e_seg, e_dp, e_ack, bnd});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (load_ack) ack_seen++;
        n_checks++;
        if ({an, seg, dp, load_ack, frame_start} === e) n_pass++;
        else $display("FAIL cycle sel=%0d t=%0t: got an=%h seg=%h dp=%b ack=%b fs=%b expected an=%h seg=%h dp=%b ack=%b fs=%b",
                      s, $time, an, seg, dp, load_ack, frame_start,
                      e[17:10], e[9:3], e[2], e[1], e[0]);
        load = 1'b0;
    endtask

    task automatic hold(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 32'd0, 8'd0);
    endtask

    int acks_before;
    logic [6:0] exp_hi;

    initial begin
        tbl[0] = '{3'd1, 1'b0, 32'h0,         8'h00, 6};
        tbl[1] = '{3'd2, 1'b0, 32'h0,         8'h00, 6};
        tbl[2] = '{3'd3, 1'b1, 32'h89AB_CDEF, 8'h01, 6};
        tbl[3] = '{3'd4, 1'b0, 32'h0,         8'h00, 6};
        tbl[4] = '{3'd5, 1'b0, 32'h0,         8'h00, 6};
        tbl[5] = '{3'd6, 1'b0, 32'h0,         8'h00, 6};
        tbl[6] = '{3'd7, 1'b0, 32'h0,         8'h00, 6};
        tbl[7] = '{3'd0, 1'b0, 32'h0,         8'h00, 1};
        tbl[8] = '{3'd0, 1'b0, 32'h0,         8'h00, 5};

        rst = 1'b1; digit_sel = 3'd0; value = 32'd0; dp_mask = 8'd0; load = 1'b0;
        #12;
        check("reset_outputs", {14'd0, an, seg, dp, load_ack, frame_start}, {14'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
        model_reset();

        // Power-up dead time then digit 0 showing 0
        hold(3'd0, 4);
        check("powerup_blank", {24'd0, an}, 32'h0000_00FF);
        hold(3'd0, 1);
        check("powerup_an", {24'd0, an}, 32'h0000_00FE);
        check("powerup_seg", {25'd0, seg}, 32'h40);

        // Table: load mid-frame, commit at 7->0
        acks_before = ack_seen;
        for (int i = 0; i < 9; i++)
            for (int r = 0; r < tbl[i].n; r++)
                step(tbl[i].sel, tbl[i].ld && (r == 0), tbl[i].val, tbl[i].dpm);
        check("commit_ack_count", ack_seen - acks_before, 1);
        check("commit_seg_d0", {25'd0, seg}, 32'h0E);
        check("commit_dp_d0", {31'd0, dp}, 32'd0);

        // Two loads in one frame: latest wins, single ack
        acks_before = ack_seen;
        step(3'd1, 1'b1, 32'h1111_1111, 8'h00);
        hold(3'd1, 5);
        step(3'd2, 1'b1, 32'h2222_2222, 8'h00);
        hold(3'd2, 5);
        for (int s = 3; s < 8; s++) hold(3'(s), 6);
        hold(3'd0, 6);
        check("two_loads_ack_count", ack_seen - acks_before, 1);
        check("two_loads_seg_d0", {25'd0, seg}, 32'h24);
        for (int s = 1; s < 8; s++) begin
            hold(3'(s), 6);
            check("two_loads_seg", {25'd0, seg}, 32'h24);
        end

        // Load exactly on the boundary: bypass staging, nothing left pending
        step(3'd0, 1'b1, 32'h0000_0005, 8'h00);
        check("boundary_load_ack", {31'd0, load_ack}, 32'd1);
        hold(3'd0, 5);
        check("boundary_load_seg", {25'd0, seg}, 32'h12);
        for (int s = 1; s < 8; s++) hold(3'(s), 6);
        acks_before = ack_seen;
        hold(3'd0, 6);
        check("no_stale_pending", ack_seen - acks_before, 0);

        // Rapid digit changes restart dead time
        hold(3'd3, 6);
        hold(3'd4, 2);
        hold(3'd5, 1);
        hold(3'd5, 4);
        check("toggle_still_blank", {24'd0, an}, 32'h0000_00FF);
        hold(3'd5, 1);
        check("toggle_an", {24'd0, an}, 32'h0000_00DF);

        // Value 0x12: leading digits depend on suppression build option
`ifdef SEG_SCAN_LZ_BLANK_EN
        exp_hi = 7'h7F;
`else
        exp_hi = 7'h40;
`endif
        hold(3'd6, 6);
        hold(3'd7, 6);
        step(3'd0, 1'b1, 32'h0000_0012, 8'h00);
        hold(3'd0, 5);
        check("lz_d0", {25'd0, seg}, 32'h24);
        hold(3'd1, 6);
        check("lz_d1", {25'd0, seg}, 32'h79);
        hold(3'd2, 6);
        check("lz_d2", {25'd0, seg}, {25'd0, exp_hi});
        hold(3'd7, 6);
        check("lz_d7", {25'd0, seg}, {25'd0, exp_hi});
        check("lz_d7_an", {24'd0, an}, 32'h0000_007F);

        // Reset mid-frame with a pending load: discarded
        step(3'd3, 1'b1, 32'h3333_3333, 8'hFF);
        #2 rst = 1'b1;
        #1;
        check("midrst_async", {14'd0, an, seg, dp, load_ack, frame_start}, {14'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check("midrst_held", {14'd0, an, seg, dp, load_ack, frame_start}, {14'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
        rst = 1'b0;
        model_reset();
        hold(3'd3, 6);
        for (int s = 4; s < 8; s++) hold(3'(s), 2);
        acks_before = ack_seen;
        hold(3'd0, 6);
        check("midrst_no_ack", ack_seen - acks_before, 0);
        check("midrst_seg_d0", {25'd0, seg}, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
